// File: rtl/pb_out_port_bank.sv
// PicoBlaze output-port decoder: TX byte FIFO with a valid/ready handshake toward the
// UART, a write/set/clear control register, and a command port for flush and overflow clear.
module pb_out_port_bank #(
  parameter int                FIFO_DEPTH    = 16,
  parameter int                CTRL_W        = 2,
  parameter logic [CTRL_W-1:0] CTRL_RESET    = '0,
  parameter logic [7:0]        TX_PORT       = 8'h01,
  parameter logic [7:0]        CTRL_PORT     = 8'h02,
  parameter logic [7:0]        CTRL_SET_PORT = 8'h03,
  parameter logic [7:0]        CTRL_CLR_PORT = 8'h04,
  parameter logic [7:0]        CMD_PORT      = 8'h05,
  localparam int               AW            = $clog2(FIFO_DEPTH),
  localparam int               CW            = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        port_id,
  input  logic [7:0]        out_port,
  input  logic              write_strobe,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [CW-1:0]     tx_count,
  output logic              tx_full,
  output logic              tx_overflow
);

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [CTRL_W-1:0] ctrl;

  logic push_req, push_ok, push_drop, pop, flush, clr_ovf;
  logic ctrl_wr, ctrl_set, ctrl_clr, cmd_wr;

  assign push_req = write_strobe && (port_id == TX_PORT);
  assign ctrl_wr  = write_strobe && (port_id == CTRL_PORT);
  assign ctrl_set = write_strobe && (port_id == CTRL_SET_PORT);
  assign ctrl_clr = write_strobe && (port_id == CTRL_CLR_PORT);
  assign cmd_wr   = write_strobe && (port_id == CMD_PORT);

  assign tx_valid  = (count != '0);
  assign tx_full   = (count == CW'(FIFO_DEPTH));
  assign pop       = tx_valid && tx_ready;
  assign flush     = cmd_wr && out_port[0];
  assign clr_ovf   = cmd_wr && out_port[1];
  // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
  assign push_ok   = push_req && (!tx_full || pop);
  assign push_drop = push_req && tx_full && !pop;

  // Storage carries no reset; an empty FIFO masks tx_data to zero instead.
  // NOTE: memories are left unreset so they map onto plain RAM; validity lives in count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= out_port;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ctrl     <= CTRL_RESET;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop)      count <= count + 1'b1;
        else if (pop && !push_ok) count <= count - 1'b1;
      end

      if (clr_ovf)        overflow <= 1'b0;
      else if (push_drop) overflow <= 1'b1;

      if (ctrl_wr)       ctrl <= out_port[CTRL_W-1:0];
      else if (ctrl_set) ctrl <= ctrl | out_port[CTRL_W-1:0];
      else if (ctrl_clr) ctrl <= ctrl & ~out_port[CTRL_W-1:0];
    end
  end

  assign tx_data     = tx_valid ? mem[rd_ptr] : 8'h00;
  assign tx_count    = count;
  assign tx_overflow = overflow;
  assign ctrl_out    = ctrl;

endmodule

// File: tb/tb_pb_out_port_bank.sv
// Self-checking bench for pb_out_port_bank: directed scenarios plus randomized traffic
// checked against a queue-based model of the port bank.
module tb_pb_out_port_bank;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] port_id = '0;
  logic [7:0] out_port = '0;
  logic       write_strobe = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [1:0] ctrl_out;
  logic [4:0] tx_count;
  logic       tx_full;
  logic       tx_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  byte unsigned mq[$];
  logic [1:0]   m_ctrl = 2'b10;
  logic         m_ovf = 1'b0;

  pb_out_port_bank #(
    .FIFO_DEPTH(DEPTH),
    .CTRL_W(2),
    .CTRL_RESET(2'b10)
  ) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ctrl_out(ctrl_out), .tx_count(tx_count),
    .tx_full(tx_full), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  // Applies one cycle of inputs, advances the model by the same rules, samples #1 after the edge.
  task automatic step(input logic ws, input logic [7:0] pid, input logic [7:0] dat,
                      input logic rdy, input logic rst);
    bit do_pop;
    write_strobe = ws; port_id = pid; out_port = dat; tx_ready = rdy; reset = rst;
    do_pop = (mq.size() > 0) && rdy;
    if (rst) begin
      mq.delete(); m_ovf = 1'b0; m_ctrl = 2'b10;
    end else if (ws) begin
      case (pid)
        8'h01: begin
          if (mq.size() == DEPTH && !do_pop) m_ovf = 1'b1;
          else begin
            if (do_pop) void'(mq.pop_front());
            do_pop = 0;
            mq.push_back(dat);
          end
        end
        8'h02: m_ctrl = dat[1:0];
        8'h03: m_ctrl = m_ctrl | dat[1:0];
        8'h04: m_ctrl = m_ctrl & ~dat[1:0];
        8'h05: begin
          if (dat[0]) begin mq.delete(); do_pop = 0; end
          if (dat[1]) m_ovf = 1'b0;
        end
        default: ;
      endcase
    end
    if (!rst && do_pop) void'(mq.pop_front());
    @(posedge clk);
    #1;
    write_strobe = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (ctrl_out !== 2'b10) begin errors++; $display("FAIL reset_ctrl got %h exp 2", ctrl_out); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", tx_valid); end
    checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", tx_count); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", tx_overflow); end
    checks++; if (tx_full !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_full_data got %b/%h exp 0/00", tx_full, tx_data); end
  endtask

  task automatic test_tx_basic();
    step(1'b1, 8'h01, 8'h41, 1'b0, 1'b0);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41 || tx_count !== 5'd1) begin
      errors++; $display("FAIL tx_push got v=%b d=%h c=%0d exp v=1 d=41 c=1", tx_valid, tx_data, tx_count); end
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      errors++; $display("FAIL tx_hold got v=%b d=%h exp v=1 d=41", tx_valid, tx_data); end
    step(1'b1, 8'h07, 8'h55, 1'b1, 1'b0);
    checks++; if (tx_valid !== 1'b0 || tx_count !== 5'd0) begin
      errors++; $display("FAIL tx_pop got v=%b c=%0d exp v=0 c=0", tx_valid, tx_count); end
  endtask

  task automatic test_ctrl();
    logic [7:0] pids [3] = '{8'h02, 8'h04, 8'h03};
    logic [7:0] dats [3] = '{8'hF3, 8'hFD, 8'h01};
    logic [1:0] exps [3] = '{2'b11, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pids[i], dats[i], 1'b0, 1'b0);
      checks++; if (ctrl_out !== exps[i]) begin
        errors++; $display("FAIL ctrl_op%0d got %b exp %b", i, ctrl_out, exps[i]); end
    end
    step(1'b0, 8'h02, 8'h00, 1'b0, 1'b0);
    checks++; if (ctrl_out !== 2'b11) begin errors++; $display("FAIL ctrl_nostrobe got %b exp 11", ctrl_out); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) step(1'b1, 8'h01, 8'(i), 1'b0, 1'b0);
    checks++; if (tx_full !== 1'b1 || tx_overflow !== 1'b1 || tx_count !== 5'd16) begin
      errors++; $display("FAIL ovf_state got f=%b o=%b c=%0d exp f=1 o=1 c=16", tx_full, tx_overflow, tx_count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        errors++; $display("FAIL ovf_drain%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(i)); end
      step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (tx_valid !== 1'b0 || tx_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_empty got v=%b o=%b exp v=0 o=1", tx_valid, tx_overflow); end
    step(1'b1, 8'h05, 8'h02, 1'b0, 1'b0);
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", tx_overflow); end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h01, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h01, 8'hAA, 1'b1, 1'b0);
    checks++; if (tx_count !== 5'd16 || tx_overflow !== 1'b0 || tx_data !== 8'h01) begin
      errors++; $display("FAIL full_pp got c=%0d o=%b d=%h exp c=16 o=0 d=01", tx_count, tx_overflow, tx_data); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (tx_data !== ((i == DEPTH) ? 8'hAA : 8'(i))) begin
        errors++; $display("FAIL full_pp_drain%0d got %h", i, tx_data); end
      step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL full_pp_empty got %b exp 0", tx_valid); end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h01, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'h05, 8'h03, 1'b1, 1'b0);
    checks++; if (tx_count !== 5'd0 || tx_valid !== 1'b0 || tx_overflow !== 1'b0) begin
      errors++; $display("FAIL flush got c=%0d v=%b o=%b exp 0/0/0", tx_count, tx_valid, tx_overflow); end
    for (int i = 0; i < 4; i++) step(1'b1, 8'h01, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h02, 8'h01, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    checks++; if (tx_count !== 5'd0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || tx_full !== 1'b0
                  || tx_overflow !== 1'b0 || ctrl_out !== 2'b10) begin
      errors++; $display("FAIL mid_reset got c=%0d v=%b d=%h f=%b o=%b ctrl=%b exp 0/0/00/0/0/10",
                         tx_count, tx_valid, tx_data, tx_full, tx_overflow, ctrl_out); end
  endtask

  task automatic test_random();
    int pid;
    for (int n = 0; n < 3000; n++) begin
      pid = $urandom_range(0, 7);
      if (pid == 5 && ($urandom % 6) != 0) pid = 1;
      step(1'($urandom), 8'(pid), 8'($urandom), ($urandom % 3) == 0, ($urandom % 200) == 0);
      checks++;
      if (tx_valid !== (mq.size() != 0) || tx_count !== 5'(mq.size())
          || tx_full !== (mq.size() == DEPTH) || tx_overflow !== m_ovf || ctrl_out !== m_ctrl
          || tx_data !== ((mq.size() != 0) ? mq[0] : 8'h00)) begin
        errors++;
        $display("FAIL rand%0d got v=%b c=%0d f=%b o=%b ctrl=%b d=%h exp c=%0d o=%b ctrl=%b d=%h",
                 n, tx_valid, tx_count, tx_full, tx_overflow, ctrl_out, tx_data,
                 mq.size(), m_ovf, m_ctrl, (mq.size() != 0) ? mq[0] : 8'h00);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_tx_basic();
    test_ctrl();
    test_overflow();
    test_full_pushpop();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
